wb_rr_arbiter_n: RTL and testbench

//  N-master -> 1-slave Wishbone classic arbiter; generalises the fixed two-master front end of soc_core.

---
 rtl/wb_rr_arbiter_n.sv | 137 +++++++++++++
 tb/tb_wb_rr_arbiter_n.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter_n.sv
// N-master to single-slave Wishbone classic arbiter with round-robin grant,
// per-cycle ownership lock and a stalled-slave watchdog that terminates with err.
module wb_rr_arbiter_n #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic                            clk,
  input  logic                            RESET,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_adr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_sel,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ack,
  output logic [NUM_MASTERS-1:0]          grant,
  output logic                            busy
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       own;
  logic [IDX_W-1:0]       last;
  logic [WD_W-1:0]        wdog;

  logic [NUM_MASTERS-1:0] req;
  logic                   req_found;
  logic [IDX_W-1:0]       req_pick;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   wd_fire;

  assign req     = m_cyc & m_stb;
  assign busy    = (state == BUSY);
  assign grant   = grant_q;
  assign own_cyc = busy & m_cyc[own];
  assign own_stb = busy & m_stb[own];

  // Search starts one past the previous owner so every requester is reached within N arbitrations.
  always_comb begin
    int unsigned cand;
    req_found = 1'b0;
    req_pick  = '0;
    cand      = 0;
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      cand = (32'(last) + off) % NUM_MASTERS;
      if (!req_found && req[cand]) begin
        req_found = 1'b1;
        req_pick  = IDX_W'(cand);
      end
    end
  end

  // A same-cycle ack beats the timeout, so the fire term excludes s_ack.
  assign wd_fire = (TIMEOUT != 0) && own_cyc && own_stb && !s_ack && (wdog == WD_LAST);

  always_comb begin
    s_adr   = '0;
    s_wdata = '0;
    s_sel   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        s_adr   = m_adr[i*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
        s_sel   = m_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign s_cyc   = own_cyc & ~wd_fire;
  assign s_stb   = own_stb & ~wd_fire;
  assign s_we    = busy & m_we[own];
  assign m_rdata = busy ? s_rdata : '0;
  assign m_ack   = grant_q & {NUM_MASTERS{s_ack}};
  assign m_err   = grant_q & {NUM_MASTERS{wd_fire}};

  always_ff @(posedge clk) begin
    if (RESET) begin
      state   <= IDLE;
      grant_q <= '0;
      own     <= '0;
      last    <= IDX_W'(NUM_MASTERS - 1);
      wdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (req_found) begin
            grant_q <= NUM_MASTERS'(1) << req_pick;
            own     <= req_pick;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc || wd_fire) begin
            grant_q <= '0;
            last    <= own;
            wdog    <= '0;
            state   <= IDLE;
          end else if (own_stb && !s_ack) begin
            wdog <= wdog + WD_W'(1);
          end else begin
            wdog <= '0;
          end
        end
        default: begin
          grant_q <= '0;
          wdog    <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter_n.sv
// Bench for wb_rr_arbiter_n (4 masters, 16-cycle watchdog): a per-cycle
// reference model compared at every falling edge, plus hand-computed checks.
module tb_wb_rr_arbiter_n;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TOUT = 16;

  logic            clk = 1'b0;
  logic            RESET;
  logic [N-1:0]    cyc, stb, we;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] wdata;
  logic [N*SW-1:0] sel;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ack, m_err;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_sel;
  logic [DW-1:0]   s_rdata;
  logic            s_ack;
  logic [N-1:0]    grant;
  logic            busy;

  int errors = 0;
  int checks = 0;

  wb_rr_arbiter_n #(
    .NUM_MASTERS(N),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk    (clk),
    .RESET  (RESET),
    .m_cyc  (cyc),
    .m_stb  (stb),
    .m_we   (we),
    .m_adr  (adr),
    .m_wdata(wdata),
    .m_sel  (sel),
    .m_rdata(m_rdata),
    .m_ack  (m_ack),
    .m_err  (m_err),
    .s_cyc  (s_cyc),
    .s_stb  (s_stb),
    .s_we   (s_we),
    .s_adr  (s_adr),
    .s_wdata(s_wdata),
    .s_sel  (s_sel),
    .s_rdata(s_rdata),
    .s_ack  (s_ack),
    .grant  (grant),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when idle), previous owner, count of waiting cycles so far.
  int  mo = -1;
  int  ml = N - 1;
  int  mw = 0;
  bit  model_on = 1'b0;

  function automatic bit model_fire();
    if (mo < 0) return 1'b0;
    return cyc[mo] && stb[mo] && !s_ack && (mw + 1 == TOUT);
  endfunction

  always @(posedge clk) begin
    if (RESET) begin
      mo = -1;
      ml = N - 1;
      mw = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (mo < 0) begin
        for (int off = 1; off <= N; off++) begin
          int c;
          c = (ml + off) % N;
          if (mo < 0 && cyc[c] && stb[c]) mo = c;
        end
        mw = 0;
      end else if (!cyc[mo] || model_fire()) begin
        ml = mo;
        mo = -1;
        mw = 0;
      end else if (stb[mo] && !s_ack) begin
        mw = mw + 1;
      end else begin
        mw = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      bit b, f;
      b = (mo >= 0);
      f = model_fire();
      check("grant",   grant,   b ? (N'(1) << mo) : '0);
      check("busy",    busy,    b);
      check("s_cyc",   s_cyc,   b && cyc[mo] && !f);
      check("s_stb",   s_stb,   b && stb[mo] && !f);
      check("s_we",    s_we,    b && we[mo]);
      check("s_adr",   s_adr,   b ? adr[mo*AW +: AW] : '0);
      check("s_wdata", s_wdata, b ? wdata[mo*DW +: DW] : '0);
      check("s_sel",   s_sel,   b ? sel[mo*SW +: SW] : '0);
      check("m_ack",   m_ack,   (b && s_ack) ? (N'(1) << mo) : '0);
      check("m_err",   m_err,   f ? (N'(1) << mo) : '0);
      check("m_rdata", m_rdata, b ? s_rdata : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc = '0; stb = '0; s_ack = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic wait_grant(output int idx);
    int n;
    n = 0;
    idx = -1;
    while (grant == '0 && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < N; i++) if (grant[i]) idx = i;
    if (idx < 0) begin
      errors++;
      $display("FAIL wait_grant: no grant within 20 cycles");
    end
  endtask

  initial begin
    int order [5];
    int exp_order [5];
    int g, n;
    exp_order = '{0, 1, 2, 3, 0};
    RESET = 1'b1;
    cyc = '0; stb = '0; we = '0; s_ack = 1'b0;
    s_rdata = 32'h1234_5678;
    for (int i = 0; i < N; i++) begin
      adr[i*AW +: AW]   = 32'h0000_4000 + 32'(i) * 32'h100;
      wdata[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
      sel[i*SW +: SW]   = 4'(i + 1);
    end

    // 1: reset state, then single write from master 0
    tick(); tick();
    RESET = 1'b0;
    check("t1_reset_grant", grant, 4'b0000);
    check("t1_reset_scyc", s_cyc, 1'b0);
    adr[0 +: AW] = 32'h0000_1000; wdata[0 +: DW] = 32'hDEAD_BEEF; sel[0 +: SW] = 4'hF;
    we[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    check("t1_grant", grant, 4'b0001);
    check("t1_s_adr", s_adr, 32'h0000_1000);
    check("t1_s_wdata", s_wdata, 32'hDEAD_BEEF);
    s_ack = 1'b1;
    #1;
    check("t1_m_ack", m_ack, 4'b0001);
    tick();
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    tick();
    check("t1_release", grant, 4'b0000);

    // 2: all four request continuously, one ack each
    do_reset();
    cyc = '1; stb = '1;
    for (int k = 0; k < 5; k++) begin
      s_rdata = 32'hCAFE_0000 + 32'(k);
      wait_grant(g);
      order[k] = g;
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      if (g >= 0) begin cyc[g] = 1'b0; stb[g] = 1'b0; end
      tick();
      check("t2_idle_gap", grant, 4'b0000);
      if (g >= 0) begin cyc[g] = 1'b1; stb[g] = 1'b1; end
    end
    for (int k = 0; k < 5; k++) check($sformatf("t2_order%0d", k), 32'(order[k]), 32'(exp_order[k]));

    // 3: master 1 block transfer of 4 beats while master 0 waits
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    check("t3_grant1", grant, 4'b0010);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0; stb[1] = 1'b0;
      check("t3_hold_a", grant, 4'b0010);
      tick();
      stb[1] = 1'b1;
      check("t3_hold_b", grant, 4'b0010);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    check("t3_idle", grant, 4'b0000);
    tick();
    check("t3_next_owner", grant, 4'b0001);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    tick();

    // 4: slave never acks -> watchdog error
    do_reset();
    cyc[2] = 1'b1; stb[2] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (m_err == '0 && n < 40);
    check("t4_err_cycle", 32'(n), 32'd16);
    check("t4_err_vec", m_err, 4'b0100);
    check("t4_scyc_forced", s_cyc, 1'b0);
    tick();
    check("t4_grant_cleared", grant, 4'b0000);
    tick();
    check("t4_regrant", grant, 4'b0100);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    tick();

    // 5: ack on the last watchdog cycle wins, counter restarts
    do_reset();
    cyc[3] = 1'b1; stb[3] = 1'b1;
    n = 0;
    g = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (m_err != '0) g++;
    end
    check("t5_no_early_err", 32'(g), 32'd0);
    tick();
    s_rdata = 32'h0BAD_F00D;
    s_ack = 1'b1;
    #1;
    check("t5_ack", m_ack, 4'b1000);
    check("t5_no_err", m_err, 4'b0000);
    check("t5_rdata", m_rdata, 32'h0BAD_F00D);
    tick();
    s_ack = 1'b0;
    n = 1;
    while (m_err == '0 && n < 40) begin tick(); n++; end
    check("t5_wdog_restart", 32'(n), 32'd16);
    cyc[3] = 1'b0; stb[3] = 1'b0;
    tick();

    // 6: reset during a read, late ack discarded, master 0 first afterwards
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0;
    tick();
    check("t6_grant_pre", grant, 4'b0010);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    s_ack = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    #1;
    check("t6_scyc", s_cyc, 1'b0);
    check("t6_grant", grant, 4'b0000);
    check("t6_ack_dropped", m_ack, 4'b0000);
    check("t6_no_err", m_err, 4'b0000);
    tick();
    s_ack = 1'b0;
    check("t6_first_win", grant, 4'b0001);
    cyc = '0; stb = '0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
